// File: rtl/nios_multi_timer_pkg.sv
// rtl/nios_multi_timer_pkg.sv - register offsets and bit indices for the multi-channel timer
package nios_multi_timer_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAP     = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_PENDING  = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

endpackage

// File: rtl/nios_timer_channel.sv
// rtl/nios_timer_channel.sv - one timer channel: prescaler, down-counter, snapshot, TO/RUN
module nios_timer_channel #(
  parameter int CNT_W      = 32,
  parameter int DATA_W     = 32,
  parameter int PRE_W      = 16,
  parameter int RST_PERIOD = 49999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_status_i,
  input  logic              wr_ctrl_i,
  input  logic              wr_period_i,
  input  logic              wr_snap_i,
  input  logic              wr_prescale_i,
  input  logic [3:0]        ctrl_wdata_i,
  input  logic [CNT_W-1:0]  cnt_wdata_i,
  input  logic [PRE_W-1:0]  pre_wdata_i,
  input  logic [2:0]        reg_sel_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              irq_o
);
  import nios_multi_timer_pkg::*;

  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RST_PERIOD);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             ito_q, ito_d;
  logic             cont_q, cont_d;
  logic             to_q, to_d;
  logic             run_q, run_d;

  logic tick, expire, start, stop, fresh_start;
  logic [1:0] status_w, ctrl_w;

  // Next-state: later assignments take priority (START over STOP, timeout over STATUS clear)
  always_comb begin
    tick        = run_q && (pre_q == prescale_q);
    expire      = tick && (count_q == '0);
    start       = wr_ctrl_i && ctrl_wdata_i[CTRL_START];
    stop        = wr_ctrl_i && ctrl_wdata_i[CTRL_STOP];
    fresh_start = start && !run_q;

    count_d    = count_q;
    period_d   = period_q;
    snap_d     = snap_q;
    pre_d      = pre_q;
    prescale_d = prescale_q;
    ito_d      = ito_q;
    cont_d     = cont_q;
    to_d       = to_q;
    run_d      = run_q;

    if (run_q) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
    if (tick) begin
      count_d = expire ? period_q : count_q - CNT_W'(1);
    end
    if (expire && !cont_q) begin
      run_d = 1'b0;
    end

    if (wr_ctrl_i) begin
      ito_d  = ctrl_wdata_i[CTRL_ITO];
      cont_d = ctrl_wdata_i[CTRL_CONT];
    end
    if (fresh_start) begin
      count_d = period_q;
      pre_d   = '0;
    end
    if (wr_period_i) begin
      period_d = cnt_wdata_i;
      count_d  = cnt_wdata_i;
      run_d    = 1'b0;
    end
    if (stop) begin
      run_d = 1'b0;
    end
    if (start) begin
      run_d = 1'b1;
    end
    if (wr_prescale_i) begin
      prescale_d = pre_wdata_i;
      pre_d      = '0;
    end
    // snapshot always sees the count as it stood before this edge
    if (wr_snap_i) begin
      snap_d = count_q;
    end

    if (wr_status_i) begin
      to_d = 1'b0;
    end
    if (expire) begin
      to_d = 1'b1;
    end
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= RST_CNT;
      period_q   <= RST_CNT;
      snap_q     <= '0;
      pre_q      <= '0;
      prescale_q <= '0;
      ito_q      <= 1'b0;
      cont_q     <= 1'b0;
      to_q       <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      period_q   <= period_d;
      snap_q     <= snap_d;
      pre_q      <= pre_d;
      prescale_q <= prescale_d;
      ito_q      <= ito_d;
      cont_q     <= cont_d;
      to_q       <= to_d;
      run_q      <= run_d;
    end
  end

  // Readback word for the selected register, zero-extended
  always_comb begin
    status_w             = '0;
    status_w[STATUS_TO]  = to_q;
    status_w[STATUS_RUN] = run_q;
    ctrl_w               = '0;
    ctrl_w[CTRL_ITO]     = ito_q;
    ctrl_w[CTRL_CONT]    = cont_q;
    case (reg_sel_i)
      REG_STATUS:   rdata_o = DATA_W'(status_w);
      REG_CONTROL:  rdata_o = DATA_W'(ctrl_w);
      REG_PERIOD:   rdata_o = DATA_W'(period_q);
      REG_SNAP:     rdata_o = DATA_W'(snap_q);
      REG_PRESCALE: rdata_o = DATA_W'(prescale_q);
      default:      rdata_o = '0;
    endcase
    irq_o = to_q && ito_q;
  end

endmodule

// File: rtl/nios_system_multi_timer.sv
// rtl/nios_system_multi_timer.sv - N-channel interval timer with Avalon-MM slave and irq vector
module nios_system_multi_timer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int DATA_W     = 32,
  parameter int PRE_W      = 16,
  parameter int RST_PERIOD = 49999
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3+$clog2(NUM_CH)-1:0] address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [DATA_W-1:0]           writedata,
  output logic [DATA_W-1:0]           readdata,
  output logic                        irq,
  output logic [NUM_CH-1:0]           irq_vec
);
  import nios_multi_timer_pkg::*;

  localparam int ADDR_W = 3 + $clog2(NUM_CH);

  logic [ADDR_W-1:0] ch_sel;
  logic [2:0]        reg_off;
  logic              ch_ok;
  logic              wr_en;

  logic [DATA_W-1:0] rdata_ch [NUM_CH];
  logic [NUM_CH-1:0] irq_raw;

  logic [DATA_W-1:0] readdata_q, readdata_d, rd_mux;
  logic [NUM_CH-1:0] irq_vec_q;
  logic              irq_q;

  assign ch_sel  = address >> 3;
  assign reg_off = address[2:0];
  assign ch_ok   = ch_sel < ADDR_W'(NUM_CH);
  assign wr_en   = chipselect && !write_n && ch_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_ch;
    assign wr_ch = wr_en && (ch_sel == ADDR_W'(i));

    nios_timer_channel #(
      .CNT_W      (CNT_W),
      .DATA_W     (DATA_W),
      .PRE_W      (PRE_W),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .wr_status_i   (wr_ch && (reg_off == REG_STATUS)),
      .wr_ctrl_i     (wr_ch && (reg_off == REG_CONTROL)),
      .wr_period_i   (wr_ch && (reg_off == REG_PERIOD)),
      .wr_snap_i     (wr_ch && (reg_off == REG_SNAP)),
      .wr_prescale_i (wr_ch && (reg_off == REG_PRESCALE)),
      .ctrl_wdata_i  (writedata[3:0]),
      .cnt_wdata_i   (writedata[CNT_W-1:0]),
      .pre_wdata_i   (writedata[PRE_W-1:0]),
      .reg_sel_i     (reg_off),
      .rdata_o       (rdata_ch[i]),
      .irq_o         (irq_raw[i])
    );
  end

  // Read mux: pending summary is shared, out-of-range channels read 0
  always_comb begin
    rd_mux = '0;
    if (ch_ok) begin
      if (reg_off == REG_PENDING) begin
        rd_mux = DATA_W'(irq_vec_q);
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_sel == ADDR_W'(i)) begin
            rd_mux = rdata_ch[i];
          end
        end
      end
    end
    readdata_d = (chipselect && write_n) ? rd_mux : readdata_q;
  end

  // Registered read data and interrupt outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
      irq_vec_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      irq_vec_q  <= irq_raw;
      irq_q      <= |irq_raw;
    end
  end

  assign readdata = readdata_q;
  assign irq_vec  = irq_vec_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_system_multi_timer.sv
// tb/tb_nios_system_multi_timer.sv - directed self-checking bench for the multi-channel timer
module tb_nios_system_multi_timer;

  localparam int NUM_CH = 3;

  logic        clk;
  logic        reset;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [2:0]  irq_vec;

  int tests;
  int fails;
  logic [31:0] d;

  nios_system_multi_timer #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (32),
    .DATA_W     (32),
    .PRE_W      (16),
    .RST_PERIOD (49999)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] v);
    address    = 5'((ch << 3) | r);
    writedata  = v;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] v);
    address    = 5'((ch << 3) | r);
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick(1);
    chipselect = 1'b0;
    v = readdata;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    tick(2);
    reset = 1'b0;

    // reset state
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_irq_vec", {29'd0, irq_vec}, 32'd0);
    rd(0, 2, d); check("rst_period_ch0", d, 32'd49999);
    rd(0, 0, d); check("rst_status_ch0", d, 32'd0);
    rd(0, 4, d); check("rst_prescale_ch0", d, 32'd0);

    // ch1 continuous, period 3, no prescale: timeout every 4 clocks
    wr(1, 2, 32'd3);
    wr(1, 4, 32'd0);
    wr(1, 1, 32'h7);
    rd(1, 1, d); check("ch1_ctrl_readback", d, 32'h3);
    tick(2);     check("ch1_irq_before_to", {31'd0, irq_vec[1]}, 32'd0);
    tick(1);     check("ch1_irq_lags_to", {31'd0, irq_vec[1]}, 32'd0);
    rd(1, 0, d); check("ch1_status_to_run", d, 32'h3);
    check("ch1_irq_vec_set", {31'd0, irq_vec[1]}, 32'd1);
    check("ch1_irq_or", {31'd0, irq}, 32'd1);
    wr(1, 0, 32'd0);
    check("ch1_irq_after_clear_edge", {31'd0, irq_vec[1]}, 32'd1);
    tick(1);     check("ch1_irq_cleared", {31'd0, irq_vec[1]}, 32'd0);
    tick(1);     check("ch1_irq_next_to_lag", {31'd0, irq_vec[1]}, 32'd0);
    rd(0, 5, d); check("pending_before_2nd", d, 32'h0);
    check("ch1_irq_second_to", {31'd0, irq_vec[1]}, 32'd1);
    rd(0, 5, d); check("pending_ch1", d, 32'h2);
    wr(1, 1, 32'h8);
    wr(1, 0, 32'd0);

    // ch0 one-shot, period 2, prescale 4: timeout 15 clocks after start
    wr(0, 2, 32'd2);
    wr(0, 4, 32'd4);
    wr(0, 1, 32'h5);
    tick(14);
    rd(0, 0, d); check("ch0_status_pre_to", d, 32'h2);
    rd(0, 0, d); check("ch0_status_to_stop", d, 32'h1);
    check("ch0_irq_vec", {29'd0, irq_vec}, 32'h1);
    wr(0, 3, 32'd0);
    rd(0, 3, d); check("ch0_count_reloaded", d, 32'd2);
    wr(0, 0, 32'd0);
    wr(0, 1, 32'd0);

    // ch2 running: snapshots track the live count
    wr(2, 2, 32'd100);
    wr(2, 4, 32'd0);
    wr(2, 1, 32'h6);
    tick(4);
    wr(2, 3, 32'hFFFF_FFFF);
    rd(2, 3, d); check("ch2_snap_first", d, 32'd96);
    tick(10);
    wr(2, 3, 32'd0);
    rd(2, 3, d); check("ch2_snap_second", d, 32'd84);
    rd(2, 1, d); check("ch2_ctrl_readback", d, 32'h2);
    rd(2, 0, d); check("ch2_status_run", d, 32'h2);
    wr(2, 1, 32'h8);

    // START|STOP: START wins; STATUS write coinciding with timeout keeps TO
    wr(1, 1, 32'hC);
    rd(1, 0, d); check("ch1_start_wins", d, 32'h2);
    tick(2);
    wr(1, 0, 32'd0);
    rd(1, 0, d); check("ch1_to_beats_clear", d, 32'h1);
    check("irq_ito_off", {31'd0, irq}, 32'd0);

    // mid-run reset with irq high
    wr(0, 2, 32'd1);
    wr(0, 4, 32'd0);
    wr(0, 1, 32'h7);
    rd(0, 2, d); check("ch0_period_one", d, 32'd1);
    tick(3);
    check("irq_high_pre_reset", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_irq_vec", {29'd0, irq_vec}, 32'd0);
    check("reset_readdata", readdata, 32'd0);
    wr(0, 3, 32'd0);
    rd(0, 3, d); check("reset_count", d, 32'd49999);
    rd(0, 0, d); check("reset_status", d, 32'd0);

    // out-of-range channel and reserved offsets
    wr(3, 2, 32'd5);
    wr(3, 4, 32'd7);
    wr(3, 1, 32'h7);
    wr(3, 3, 32'd0);
    wr(0, 6, 32'hFF);
    rd(3, 2, d); check("badch_read", d, 32'd0);
    rd(3, 5, d); check("badch_pending", d, 32'd0);
    rd(0, 2, d); check("badch_ch0_period", d, 32'd49999);
    rd(1, 2, d); check("badch_ch1_period", d, 32'd49999);
    rd(2, 2, d); check("badch_ch2_period", d, 32'd49999);
    rd(1, 0, d); check("badch_ch1_status", d, 32'd0);
    rd(0, 3, d); check("badch_ch0_snap", d, 32'd49999);
    rd(0, 6, d); check("reserved_read", d, 32'd0);
    tick(3);
    check("badch_irq", {31'd0, irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
